// File: rtl/trdb_apb_regif.sv
`default_nettype none
// trdb_apb_regif: APB3 slave for the trace encoder control/status registers.
// Define TRDB_TRIG_CNT_EN to map the TRIG_CNT register at offset 0xC.
module trdb_apb_regif #(
   parameter int unsigned ADDR_W   = 4,
   parameter logic [31:0] ID_VALUE = 32'h7DB0_0001
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [ADDR_W-1:0] paddr_i,
   input  logic [31:0]       pwdata_i,
   output logic [31:0]       prdata_o,
   output logic              pready_o,
   output logic              pslverr_o,
   input  logic              trace_req_on_i,
   input  logic              trace_req_off_i,
   output logic              trace_activated_o,
   output logic              trace_enable_o,
   output logic              nocontext_o,
   output logic              notime_o,
   output logic              delta_address_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-3:0] r_word;
   logic              r_write;
   logic [5:0]        r_wdata;
   logic              r_activated, r_nocontext, r_notime, r_delta;
   logic              r_enable, r_off_seen;

   logic w_resp, w_sel_ctrl, w_sel_status, w_sel_id, w_mapped;
   logic w_ctrl_wr, w_sw_on, w_sw_off, w_w1c, w_activated_nxt;
   logic w_enable_nxt, w_off_set;
   logic w_unused;

   assign w_unused = ^{pwdata_i[31:6], paddr_i[1:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (psel_i && penable_i) w_state_nxt = S_WAIT;
         S_WAIT:  w_state_nxt = psel_i ? S_RESP : S_IDLE;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Transfer attributes are captured once so the response never depends on live bus inputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_word  <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
      end else if (r_state == S_IDLE && psel_i && penable_i) begin
         r_word  <= paddr_i[ADDR_W-1:2];
         r_write <= pwrite_i;
         r_wdata <= pwdata_i[5:0];
      end
   end

   assign w_resp       = (r_state == S_RESP);
   assign w_sel_ctrl   = (r_word == (ADDR_W-2)'(0));
   assign w_sel_status = (r_word == (ADDR_W-2)'(1));
   assign w_sel_id     = (r_word == (ADDR_W-2)'(2));

`ifdef TRDB_TRIG_CNT_EN
   logic [31:0] r_trig_cnt;
   logic        w_sel_cnt;
   assign w_sel_cnt = (r_word == (ADDR_W-2)'(3));
   assign w_mapped  = w_sel_ctrl | w_sel_status | w_sel_id | w_sel_cnt;

   // A clearing write takes precedence over a rising edge of trace_enable in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                             r_trig_cnt <= '0;
      else if (w_resp && r_write && w_sel_cnt) r_trig_cnt <= '0;
      else if (!r_enable && w_enable_nxt)      r_trig_cnt <= r_trig_cnt + 32'd1;
   end
`else
   assign w_mapped = w_sel_ctrl | w_sel_status | w_sel_id;
`endif

   assign w_ctrl_wr       = w_resp && r_write && w_sel_ctrl;
   assign w_sw_on         = w_ctrl_wr && r_wdata[4];
   assign w_sw_off        = w_ctrl_wr && r_wdata[5];
   assign w_w1c           = w_resp && r_write && w_sel_status && r_wdata[1];
   assign w_activated_nxt = w_ctrl_wr ? r_wdata[0] : r_activated;

   always_comb begin
      w_enable_nxt = r_enable;
      w_off_set    = 1'b0;
      if (!w_activated_nxt) begin
         w_enable_nxt = 1'b0;
      end else if (trace_req_off_i) begin
         w_enable_nxt = 1'b0;
         w_off_set    = 1'b1;
      end else if (trace_req_on_i) begin
         w_enable_nxt = 1'b1;
      end else if (w_sw_off) begin
         w_enable_nxt = 1'b0;
      end else if (w_sw_on) begin
         w_enable_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_activated <= 1'b0;
         r_nocontext <= 1'b1;
         r_notime    <= 1'b1;
         r_delta     <= 1'b1;
         r_enable    <= 1'b0;
         r_off_seen  <= 1'b0;
      end else begin
         r_activated <= w_activated_nxt;
         if (w_ctrl_wr) begin
            r_nocontext <= r_wdata[1];
            r_notime    <= r_wdata[2];
            r_delta     <= r_wdata[3];
         end
         r_enable <= w_enable_nxt;
         if (w_off_set)  r_off_seen <= 1'b1;
         else if (w_w1c) r_off_seen <= 1'b0;
      end
   end

   always_comb begin
      prdata_o  = '0;
      pready_o  = 1'b0;
      pslverr_o = 1'b0;
      if (w_resp) begin
         pready_o = 1'b1;
         if (w_sel_ctrl)        prdata_o = {28'd0, r_delta, r_notime, r_nocontext, r_activated};
         else if (w_sel_status) prdata_o = {30'd0, r_off_seen, r_enable};
         else if (w_sel_id)     prdata_o = ID_VALUE;
`ifdef TRDB_TRIG_CNT_EN
         else if (w_sel_cnt)    prdata_o = r_trig_cnt;
`endif
         if (!w_mapped) pslverr_o = 1'b1;
      end
   end

   assign trace_activated_o = r_activated;
   assign trace_enable_o    = r_enable;
   assign nocontext_o       = r_nocontext;
   assign notime_o          = r_notime;
   assign delta_address_o   = r_delta;

endmodule
`default_nettype wire

// File: tb/tb_trdb_apb_regif.sv
`default_nettype none
// tb_trdb_apb_regif: scoreboard bench for trdb_apb_regif (ADDR_W=8) with a
// cycle-level reference model of the register map and trace-enable arbitration.
module tb_trdb_apb_regif;
   localparam int unsigned AW  = 8;
   localparam logic [31:0] IDV = 32'h7DB0_0001;
`ifdef TRDB_TRIG_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [AW-1:0] paddr = '0;
   logic [31:0]   pwdata = '0;
   logic [31:0]   prdata;
   logic          pready, pslverr;
   logic          req_on = 1'b0, req_off = 1'b0;
   logic          act_o, en_o, noctx_o, notime_o, delta_o;

   trdb_apb_regif #(.ADDR_W(AW), .ID_VALUE(IDV)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata),
      .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
      .trace_req_on_i(req_on), .trace_req_off_i(req_off),
      .trace_activated_o(act_o), .trace_enable_o(en_o),
      .nocontext_o(noctx_o), .notime_o(notime_o), .delta_address_o(delta_o)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", n, a, e, cyc);
      end
   endtask

   // Reference model state
   bit          m_act = 0, m_noctx = 1, m_notime = 1, m_delta = 1, m_en = 0, m_off = 0;
   logic [31:0] m_cnt = '0;
   // Write commit scheduled for the next clock edge (the edge ending RESP)
   bit            mc_v = 0, mc_w = 0;
   logic [AW-1:0] mc_a = '0;
   logic [31:0]   mc_d = '0;

   function automatic bit is_mapped(input logic [AW-1:0] a);
      int w;
      w = int'(a) / 4;
      return (w <= 2) || (w == 3 && CNT_EN);
   endfunction

   function automatic logic [31:0] model_read(input logic [AW-1:0] a);
      int w;
      w = int'(a) / 4;
      case (w)
         0:       return {28'd0, m_delta, m_notime, m_noctx, m_act};
         1:       return {30'd0, m_off, m_en};
         2:       return IDV;
         3:       return CNT_EN ? m_cnt : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step();
      bit son, soff, w1c, cclr, nen, setoff;
      int w;
      son = 0; soff = 0; w1c = 0; cclr = 0; setoff = 0;
      if (mc_v && mc_w) begin
         w = int'(mc_a) / 4;
         if (w == 0) begin
            m_act = mc_d[0]; m_noctx = mc_d[1]; m_notime = mc_d[2]; m_delta = mc_d[3];
            son = mc_d[4]; soff = mc_d[5];
         end else if (w == 1) begin
            w1c = mc_d[1];
         end else if (w == 3 && CNT_EN) begin
            cclr = 1;
         end
      end
      nen = m_en;
      if (!m_act)        nen = 0;
      else if (req_off)  begin nen = 0; setoff = 1; end
      else if (req_on)   nen = 1;
      else if (soff)     nen = 0;
      else if (son)      nen = 1;
      if (setoff)   m_off = 1;
      else if (w1c) m_off = 0;
      if (cclr)               m_cnt = 0;
      else if (!m_en && nen)  m_cnt = m_cnt + 1;
      m_en = nen;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_act = 0; m_noctx = 1; m_notime = 1; m_delta = 1; m_en = 0; m_off = 0; m_cnt = 0;
      end else begin
         model_step();
      end
   end

   typedef struct {
      logic [31:0] data;
      bit          err;
      bit          chk_data;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   // Monitor: compares control outputs every cycle and APB responses on pready
   initial forever begin
      exp_t e;
      @(negedge clk); #1;
      chk("trace_enable_o", en_o, m_en);
      chk("trace_activated_o", act_o, m_act);
      chk("nocontext_o", noctx_o, m_noctx);
      chk("notime_o", notime_o, m_notime);
      chk("delta_address_o", delta_o, m_delta);
      if (pready) begin
         if (sbq.size() == 0) begin
            chk("unexpected_pready", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("pready_latency", cyc, e.cyc);
            chk("pslverr", pslverr, e.err);
            if (e.chk_data) chk("prdata", prdata, e.data);
         end
      end else begin
         chk("idle_prdata", prdata, 32'd0);
         chk("idle_pslverr", pslverr, 32'd0);
      end
   end

   task automatic apb(input bit wr, input logic [AW-1:0] a, input logic [31:0] d, input bit abort);
      exp_t e;
      int c;
      @(negedge clk); psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
      @(negedge clk); penable = 1; c = cyc;
      @(negedge clk);
      if (abort) begin
         psel = 0; penable = 0;
         @(negedge clk);
         return;
      end
      @(negedge clk);
      e.err      = !is_mapped(a);
      e.data     = e.err ? 32'd0 : model_read(a);
      e.chk_data = !wr || e.err;
      e.cyc      = c + 2;
      sbq.push_back(e);
      mc_v = 1; mc_w = wr; mc_a = a; mc_d = d;
      @(negedge clk); mc_v = 0; psel = 0; penable = 0;
   endtask

   task automatic pulse(input bit on, input bit off);
      @(negedge clk); req_on = on; req_off = off;
      @(negedge clk); req_on = 0; req_off = 0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1;
      #1;
      chk("rst_activated", act_o, 32'd0);
      chk("rst_nocontext", noctx_o, 32'd1);
      chk("rst_enable", en_o, 32'd0);

      apb(0, 8'h00, 0, 0);
      apb(0, 8'h08, 0, 0);

      apb(1, 8'h00, 32'h1, 0);
      pulse(1, 0);
      #1 chk("en_after_on", en_o, 32'd1);
      apb(0, 8'h04, 0, 0);

      pulse(1, 1);
      #1 chk("on_off_same_cycle", en_o, 32'd0);
      apb(0, 8'h04, 0, 0);
      apb(1, 8'h04, 32'h2, 0);
      apb(0, 8'h04, 0, 0);

      apb(1, 8'h00, 32'h0, 0);
      pulse(1, 0);
      apb(1, 8'h00, 32'h11, 0);
      #1 chk("en_after_sw_on", en_o, 32'd1);
      apb(1, 8'h00, 32'h21, 0);
      #1 chk("en_after_sw_off", en_o, 32'd0);

      apb(0, 8'hF0, 0, 0);
      apb(1, 8'hF0, 32'hF, 0);
      apb(1, 8'h08, 32'h0, 0);
      apb(0, 8'h00, 0, 0);
      apb(1, 8'h00, 32'h0, 1);
      apb(0, 8'h00, 0, 0);

      for (int i = 0; i < 3; i++) begin
         pulse(1, 0);
         pulse(0, 1);
      end
      apb(0, 8'h0C, 0, 0);
      apb(1, 8'h0C, 32'h0, 0);
      apb(0, 8'h0C, 0, 0);

      // Reset asserted while a write sits in WAIT
      @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = 8'h00; pwdata = 32'h1;
      @(negedge clk); penable = 1;
      @(negedge clk); rst_n = 0; psel = 0; penable = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      apb(0, 8'h00, 0, 0);

      for (int i = 0; i < 120; i++) begin
         logic [AW-1:0] a;
         int op;
         op = int'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: a = 8'h00;
            1: a = 8'h04;
            2: a = 8'h08;
            3: a = 8'h0C;
            4: a = 8'hF0;
            default: a = AW'($urandom_range(0, 255));
         endcase
         case (op)
            0, 1: apb(1, 8'h00 | AW'($urandom_range(0, 3)), $urandom, 0);
            2:    apb(1, a, $urandom, 0);
            3, 4: apb(0, a, 0, 0);
            5:    apb(bit'($urandom_range(0, 1)), a, $urandom, 1);
            6:    pulse(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            default: repeat ($urandom_range(1, 3)) @(negedge clk);
         endcase
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
